bus_source_arbiter: RTL
=======================

// Module: bus_source_arbiter
// PURPOSE
//  Parametrised, registered selector for the shared-bus source mux; drives mux select from NUM_SRC "<src>Out" requests.
//  Fixed-priority mode: highest index wins. Round-robin mode rotates fairly among simultaneous requesters.
//  Lock holds the current grant across multi-cycle transfers; conflict flag reports multiple simultaneous drivers.
//  Sits between control unit and bus mux; bus_sel feeds the mux select input directly.
// PARAMETERS
//  NUM_SRC  24  number of bus sources, 2..2**SEL_W; index = mux input (R0=0..R15=15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, InPort=22, C=23)
//  SEL_W    5   width of bus_sel
//  CNT_W    16  width of conflict_cnt (only with BUS_ARB_CONFLICT_CNT_EN)
// PORTS
//  clock         in   1        rising-edge clock
//  clear         in   1        synchronous reset, active-high
//  src_req       in   NUM_SRC  per-source drive request, bit i = source i
//  rr_mode       in   1        0 = fixed priority, 1 = round-robin
//  lock          in   1        hold current grant while bus_valid=1
//  bus_sel       out  SEL_W    registered index of granted source
//  bus_valid     out  1        registered; 1 = bus_sel names an active grant
//  conflict      out  1        registered; 1 = >1 request bit set in sampled cycle
//  conflict_cnt  out  CNT_W    saturating conflict-cycle count (BUS_ARB_CONFLICT_CNT_EN only)
// BEHAVIOUR
//  - One clock; clear is synchronous and active-high. clear has priority over every other input.
//  - Reset values: bus_sel=0, bus_valid=0, conflict=0, conflict_cnt=0, internal ptr=NUM_SRC-1.
//  - Latency: 1 cycle. src_req sampled at edge k -> bus_sel/bus_valid/conflict valid after edge k.
//  - Arbitration applies only in unlocked cycles, i.e. lock=0 or bus_valid=0.
//    - src_req==0: bus_valid<=0; bus_sel holds its last value; conflict<=0; ptr unchanged.
//    - Fixed priority (rr_mode=0): grant the highest set index; ptr unchanged.
//    - Round-robin (rr_mode=1): scan ptr, ptr-1, ..., 0, NUM_SRC-1, ..., ptr+1; grant the first set bit g.
//      Then ptr <= (g==0) ? NUM_SRC-1 : g-1.
//    - Any grant: bus_sel<=g, bus_valid<=1, conflict<=(popcount(src_req)>1).
//  - Locked cycle (lock=1 and bus_valid=1):
//    - bus_sel and bus_valid hold; ptr frozen; src_req ignored; conflict<=0; conflict_cnt unchanged.
//  - lock with bus_valid=0 has no effect; the cycle arbitrates normally.
//  - rr_mode may change any cycle and takes effect at the next sampling edge; ptr is preserved across mode changes.
//  - Request bits at index >= NUM_SRC do not exist. Select codes >= NUM_SRC are never produced.
//  - clear during lock or mid-rotation: all state returns to reset values on that edge.
//  - Single source only, either mode: ptr still advances under rr; grant identical to fixed priority.
// CONFIGURATION
//  - Macro BUS_ARB_CONFLICT_CNT_EN.
//  - Defined: conflict_cnt port present.
//    - +1 on every edge where conflict is loaded with 1.
//    - Saturates at 2**CNT_W-1; cleared only by clear.
//  - Undefined: conflict_cnt port and counter absent; all other behaviour identical.
// TESTING
//  1. clear=1 for 2 edges with src_req=all ones -> bus_sel=0, bus_valid=0, conflict=0, cnt=0.
//  2. rr_mode=0, src_req=0x800004 (C, R2) -> next cycle bus_sel=23, bus_valid=1, conflict=1.
//     Then src_req=0x000004 -> bus_sel=2, conflict=0.
//  3. rr_mode=1, after reset, src_req=0x000013 (R0, R1, R4) held 4 cycles -> bus_sel sequence 4, 1, 0, 4.
//  4. Grant bus_sel=5, then lock=1 for 3 cycles with src_req=0x800000 -> bus_sel stays 5, conflict=0.
//     lock=0 -> bus_sel=23.
//  5. src_req=0 after grant 7 -> bus_valid=0, bus_sel=7.
//     clear asserted mid-lock -> reset values next edge; rr scan restarts at 23.
//  6. BUS_ARB_CONFLICT_CNT_EN, CNT_W=2: 5 consecutive 2-bit requests -> conflict_cnt 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/bus_source_arbiter_if.sv
// Handshake bundle between the control unit (master) and the bus source arbiter (slave).
// The conflict_cnt wire exists only when BUS_ARB_CONFLICT_CNT_EN is defined.
interface bus_source_arbiter_if #(
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC-1:0] src_req;
    logic               rr_mode;
    logic               lock;
    logic [SEL_W-1:0]   bus_sel;
    logic               bus_valid;
    logic               conflict;
`ifdef BUS_ARB_CONFLICT_CNT_EN
    logic [CNT_W-1:0]   conflict_cnt;
`endif

`ifdef BUS_ARB_CONFLICT_CNT_EN
    modport master (
        output src_req, rr_mode, lock,
        input  bus_sel, bus_valid, conflict, conflict_cnt
    );
    modport slave (
        input  src_req, rr_mode, lock,
        output bus_sel, bus_valid, conflict, conflict_cnt
    );
`else
    modport master (
        output src_req, rr_mode, lock,
        input  bus_sel, bus_valid, conflict
    );
    modport slave (
        input  src_req, rr_mode, lock,
        output bus_sel, bus_valid, conflict
    );
`endif
endinterface

// File: rtl/bus_source_arbiter.sv
// Registered fixed-priority / round-robin source selector for the shared-bus mux, with grant lock.
// Optional saturating conflict counter enabled by BUS_ARB_CONFLICT_CNT_EN.
module bus_source_arbiter #(
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 16
) (
    input logic                   clock,
    input logic                   clear,
    bus_source_arbiter_if.slave   bus
);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

    logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
    logic             bus_valid_q, bus_valid_d;
    logic             conflict_q, conflict_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] fp_sel_s;
    logic [SEL_W-1:0] rr_sel_s;
    logic             rr_found_s;
    logic [SEL_W-1:0] rr_ptr_next_s;
    logic             multi_req_s;
    logic             locked_s;

    // Position k of the downward, wrapping scan that starts at p.
    function automatic logic [SEL_W-1:0] scan_idx(input logic [SEL_W-1:0] p, input int k);
        logic [SEL_W-1:0] k_s;
        k_s = SEL_W'(k);
        return (p >= k_s) ? (p - k_s) : (p + SEL_W'(NUM_SRC) - k_s);
    endfunction

    // Fixed priority: the last (highest) set index wins.
    always_comb begin
        fp_sel_s = {SEL_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            fp_sel_s = bus.src_req[SEL_W'(i)] ? SEL_W'(i) : fp_sel_s;
        end
    end

    // Round-robin: first set bit scanning ptr, ptr-1, ..., wrapping to NUM_SRC-1.
    always_comb begin
        rr_sel_s   = {SEL_W{1'b0}};
        rr_found_s = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rr_sel_s   = (!rr_found_s && bus.src_req[scan_idx(ptr_q, k)]) ? scan_idx(ptr_q, k) : rr_sel_s;
            rr_found_s = rr_found_s | bus.src_req[scan_idx(ptr_q, k)];
        end
        rr_ptr_next_s = (rr_sel_s == {SEL_W{1'b0}}) ? LAST_IDX : (rr_sel_s - SEL_W'(1));
    end

    assign multi_req_s = |(bus.src_req & (bus.src_req - {{(NUM_SRC-1){1'b0}}, 1'b1}));
    assign locked_s    = bus.lock & bus_valid_q;

    // Next-state selection: locked hold, idle, or a fresh grant.
    always_comb begin
        bus_sel_d   = bus_sel_q;
        bus_valid_d = bus_valid_q;
        conflict_d  = 1'b0;
        ptr_d       = ptr_q;
        if (locked_s) begin
            conflict_d = 1'b0;
        end else if (bus.src_req == {NUM_SRC{1'b0}}) begin
            bus_valid_d = 1'b0;
        end else begin
            bus_sel_d   = bus.rr_mode ? rr_sel_s : fp_sel_s;
            bus_valid_d = 1'b1;
            conflict_d  = multi_req_s;
            ptr_d       = bus.rr_mode ? rr_ptr_next_s : ptr_q;
        end
    end

    // Grant state registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            bus_sel_q   <= {SEL_W{1'b0}};
            bus_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
            ptr_q       <= LAST_IDX;
        end else begin
            bus_sel_q   <= bus_sel_d;
            bus_valid_q <= bus_valid_d;
            conflict_q  <= conflict_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.bus_sel   = bus_sel_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.conflict  = conflict_q;

`ifdef BUS_ARB_CONFLICT_CNT_EN
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    // Saturating count of edges that load conflict with 1.
    always_comb begin
        if (conflict_d && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // Counter register, cleared only by clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            conflict_cnt_q <= {CNT_W{1'b0}};
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.conflict_cnt = conflict_cnt_q;
`endif
endmodule
